// File: rtl/y86_dmem_responder.sv
// Data-memory responder for the Y86 sequential core: services 8-byte little-endian
// reads/writes over valid/ready channels with a fixed access latency and range checking.
module y86_dmem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [63:0] LAST_OK = 64'(DEPTH_BYTES - 8);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          write_q;
    logic [63:0]   addr_q, wdata_q;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          accept, do_access;
    logic          acc_write, acc_err;
    logic [63:0]   acc_addr, acc_wdata, acc_rdata;
    logic [AW-1:0] base;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                    do_access = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        acc_write = (state == IDLE) ? req_write : write_q;
        acc_addr  = (state == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
        acc_err   = (acc_addr > LAST_OK);
        base      = acc_addr[AW-1:0];
        acc_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            acc_rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (do_access) begin
                rsp_error <= acc_err;
                rsp_rdata <= (acc_err || acc_write) ? 64'd0 : acc_rdata;
            end
        end
    end

    // Storage is deliberately not reset; a reset only blocks an uncommitted write.
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule
